// File: rtl/keypad_pkg.sv
// Shared types and width helpers for the parametrised keypad scanner.
// Used by keypad_event_fifo and keypad_scanner_n.
package keypad_pkg;

  localparam int CODE_W_MAX = 16;

  typedef struct packed {
    logic [CODE_W_MAX-1:0] code;
    logic                  press;
  } key_event_t;

  function automatic int key_idx_w(input int rows, input int cols);
    return (rows * cols <= 2) ? 1 : $clog2(rows * cols);
  endfunction

  // Counter holds 0..DEBOUNCE-1; the terminal sample toggles instead of counting.
  function automatic int deb_cnt_w(input int debounce);
    return (debounce <= 2) ? 1 : $clog2(debounce);
  endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// Synchronous key-event FIFO with a valid/ready read side and a full flag.
// Push and pop in the same cycle are accepted at any occupancy, including full.
module keypad_event_fifo
  import keypad_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  key_event_t push_data,
  output logic       full,
  output logic       valid,
  input  logic       ready,
  output key_event_t data
);

  localparam int AW = $clog2(FIFO_DEPTH);

  key_event_t     mem [FIFO_DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [AW:0]    count;
  logic           pop;
  logic           wr_en;

  assign valid = (count != '0);
  assign full  = (count == (AW + 1)'(FIFO_DEPTH));
  assign pop   = valid && ready;
  assign wr_en = push && (!full || pop);
  assign data  = mem[rd_ptr];

  // NOTE: storage is not reset; count gates every read, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/keypad_scanner_n.sv
// ROWS x COLS matrix keypad scanner: divider, column rotation, per-key debounce and
// press/release event emitter. Define KEYPAD_SYNC2_EN to add a 2-flop row synchronizer.
module keypad_scanner_n
  import keypad_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 300_000,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [COLS-1:0]                  col,
  input  logic [ROWS-1:0]                  row,
  output logic                             scan,
  output logic [ROWS*COLS-1:0]             keys,
  output logic                             ev_valid,
  input  logic                             ev_ready,
  output logic [key_idx_w(ROWS,COLS)-1:0]  ev_code,
  output logic                             ev_press,
  output logic                             overflow
);

  localparam int NK  = ROWS * COLS;
  localparam int KW  = key_idx_w(ROWS, COLS);
  localparam int CW  = deb_cnt_w(DEBOUNCE);
  localparam int DW  = $clog2(SCAN_DIV);
  localparam int CIW = $clog2(COLS);
  localparam logic [CW-1:0]   DEB_LAST = CW'(DEBOUNCE - 1);
  localparam logic [COLS-1:0] COL_RST  = ~COLS'(1);

  logic [DW-1:0]   div;
  logic [CIW-1:0]  col_idx;
  logic [CW-1:0]   cnt [NK];
  logic [NK-1:0]   pending;
  logic [ROWS-1:0] row_s;
  logic [ROWS-1:0] raw;
  logic [NK-1:0]   arb_mask;
  logic [KW-1:0]   arb_idx;
  logic            push;
  logic            pop;
  logic            fifo_full;
  key_event_t      push_ev;
  key_event_t      pop_ev;
  logic            unused_code_hi;

`ifdef KEYPAD_SYNC2_EN
  logic [ROWS-1:0] row_q1;
  logic [ROWS-1:0] row_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q1 <= '1;
      row_q2 <= '1;
    end else begin
      row_q1 <= row;
      row_q2 <= row_q1;
    end
  end

  assign row_s = row_q2;
`else
  assign row_s = row;
`endif

  assign raw  = ~row_s;
  assign scan = (div == DW'(SCAN_DIV - 1));

  // Lowest-index pending key wins; two's complement isolates its bit.
  assign arb_mask = pending & (~pending + NK'(1));
  assign push     = |pending;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    arb_idx = '0;
    for (int i = NK - 1; i >= 0; i--) begin
      if (pending[i]) arb_idx = KW'(i);
    end
  end

  always_comb begin
    push_ev       = '0;
    push_ev.code  = CODE_W_MAX'(arb_idx);
    push_ev.press = keys[arb_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div      <= '0;
      col      <= COL_RST;
      col_idx  <= '0;
      keys     <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < NK; i++) cnt[i] <= '0;
    end else begin
      div     <= scan ? '0 : div + DW'(1);
      pending <= pending & ~arb_mask;
      if (push && fifo_full && !pop) overflow <= 1'b1;
      if (scan) begin
        col     <= {col[COLS-2:0], col[COLS-1]};
        col_idx <= (col_idx == CIW'(COLS - 1)) ? '0 : col_idx + CIW'(1);
        for (int r = 0; r < ROWS; r++) begin
          for (int c = 0; c < COLS; c++) begin
            if (CIW'(c) == col_idx) begin
              if (raw[r] != keys[r*COLS+c]) begin
                if (cnt[r*COLS+c] == DEB_LAST) begin
                  keys[r*COLS+c]    <= ~keys[r*COLS+c];
                  cnt[r*COLS+c]     <= '0;
                  pending[r*COLS+c] <= 1'b1;
                end else begin
                  cnt[r*COLS+c] <= cnt[r*COLS+c] + CW'(1);
                end
              end else begin
                cnt[r*COLS+c] <= '0;
              end
            end
          end
        end
      end
    end
  end

  assign pop = ev_valid && ev_ready;

  keypad_event_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_ev),
    .full     (fifo_full),
    .valid    (ev_valid),
    .ready    (ev_ready),
    .data     (pop_ev)
  );

  assign ev_code        = pop_ev.code[KW-1:0];
  assign ev_press       = pop_ev.press;
  assign unused_code_hi = ^pop_ev.code;

endmodule

// File: doc/keypad_scanner_n.md
# keypad_scanner_n

Parametrised matrix-keypad scanner that replaces the fixed 4x4 `keypad` block. It supports ROWS x COLS matrices with a programmable scan rate and per-key debounce. Alongside the level `keys` vector, it emits press and release events through a buffered valid/ready interface. It sits between the board keypad pins and the user logic that consumes key events.

## Interface
- `ROWS`, 4, number of row inputs (≥1)
- `COLS`, 4, number of column drives (≥2)
- `SCAN_DIV`, 300_000, clk cycles per column dwell; must be > ROWS+2
- `DEBOUNCE`, 3, consecutive agreeing samples required to change a key state (≥1)
- `FIFO_DEPTH`, 8, event FIFO entries (power of two, ≥2)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous reset, active-high
- `col`  out  COLS  column drive, active-low, one-hot-low
- `row`  in  ROWS  row sense, active-low (pulled high when idle)
- `scan`  out  1  one-cycle pulse at the end of each column dwell (sample instant)
- `keys`  out  ROWS*COLS  debounced key state, 1 = pressed; index = r*COLS + c
- `ev_valid`  out  1  event available
- `ev_ready`  in  1  consumer accepts event
- `ev_code`  out  $clog2(ROWS*COLS)  key index of the event
- `ev_press`  out  1  1 = press, 0 = release
- `overflow`  out  1  sticky; an event was dropped because the FIFO was full

## Operation
- **Reset values:**
  - `col` = all ones except bit 0 = 0 (column 0 active)
  - `scan` = 0, `keys` = 0, `ev_valid` = 0, `overflow` = 0
  - Divider, debounce counters, pending mask and FIFO are cleared.
- **Divider:** counts 0..SCAN_DIV-1; `scan` = 1 when the count is SCAN_DIV-1.
- **On a `scan` cycle, for active column c:**
  - Sample the row input (raw pressed = ~row).
  - Update the debounce counters for keys r*COLS+c.
  - Rotate `col` so column c+1 is active, wrapping from COLS-1 to 0.
- **Debounce, per key, updated only when its column is sampled:**
  - If raw ≠ `keys[i]`, increment cnt.
  - If raw == `keys[i]`, set cnt = 0.
  - When the incremented cnt reaches DEBOUNCE: toggle `keys[i]`, set cnt = 0, set `pending[i]`.
- **Event emitter:**
  - Each cycle, the lowest-index set pending bit is cleared and pushed as {code, press = new `keys[i]`}.
  - If the FIFO is full and not popping in the same cycle, the event is dropped and `overflow` is set.
  - `overflow` clears only on `rst`.
- **Handshake:**
  - Pop occurs when `ev_valid` && `ev_ready`.
  - `ev_code`/`ev_press` are held stable while `ev_valid` && !`ev_ready`.
  - Simultaneous push and pop is legal at any occupancy, including full.
- Events are delivered in push order. Multiple rows changing in the same dwell are pushed in ascending index on consecutive cycles.
- **`rst` mid-operation** restores all reset values in the next cycle, discards FIFO contents, and restarts the divider.

## Timing
- `scan` at cycle t → `keys`, `col` and pending bits updated by the clk edge ending t, visible in cycle t+1.
- First push happens at t+1. With an empty FIFO, `ev_valid` = 1 at t+2.
- The k-th simultaneous change is pushed at t+k.
- Press-to-`keys` latency is DEBOUNCE samples of that column, i.e. (DEBOUNCE-1) full frames + 1 dwell, where a frame = COLS*SCAN_DIV cycles.
- Columns change only on the post-`scan` edge. Rows are sampled at the end of the dwell, so each row has SCAN_DIV-1 cycles to settle.

## Configuration
- `KEYPAD_SYNC2_EN`:
  - Defined: `row` passes through a 2-flop synchronizer before sampling. This adds 2 cycles on the row path and leaves the event latency relative to `scan` unchanged.
  - Undefined: `row` is sampled directly on the `scan` edge.

## Structure
- Package `keypad_pkg`:
  - Function for the key-index width.
  - Event struct {code, press}.
  - Debounce counter width derived from DEBOUNCE.
- Sub-module `keypad_event_fifo`: synchronous FIFO, parameter FIFO_DEPTH, element = event struct, with valid/ready output, full flag and push input.
- Divider, column rotation, debounce array and pending arbiter live in the top.

## Test plan
Settings: ROWS = COLS = 4, SCAN_DIV = 8, DEBOUNCE = 3, FIFO_DEPTH = 4, `ev_ready` = 1 unless stated.
1. Hold `rst` = 1 for 2 cycles → `col` = 4'b1110, `keys` = 0, `ev_valid` = 0, `overflow` = 0. After release, `scan` pulses every 8 cycles and `col` steps 1101, 1011, 0111, 1110.
2. Drive `row`[1] = 0 whenever `col`[2] = 0, for 4 frames → `keys`[6] = 1 one cycle after the 3rd col-2 `scan`. One event is emitted: code 6, press 1. Releasing for 3 samples gives code 6, press 0.
3. Assert the press for 2 samples, then release → `keys`[6] stays 0 and no event is emitted.
4. Rows 0 and 3 pressed together on col 1 → events code 1 then code 13, both press = 1, on consecutive cycles.
5. `ev_ready` = 0 and 5 distinct press events generated → `overflow` = 1. Raising `ev_ready` delivers exactly the first 4 events in order.
6. Hold key 6 pressed and assert `rst` mid-dwell → next cycle `keys` = 0, `col` = 1110, FIFO empty. Re-debounce then yields a fresh press event for code 6.
